// File: rtl/cla_pkg.sv
// cla_pkg
// Shared types and constants for the shared-adder arbiter slice.
//   CLA_W       adder word width (64)
//   NREQ_MAX    largest supported requester count (8)
//   arb_state_e arbiter lock state
//   rsp_t       registered response word (id, sum, cout, last[, ovf])
//   next_ptr()  cyclic increment of a round-robin pointer
// Optional feature macro: CLA_ARB_OVF_EN adds the signed-overflow flag to rsp_t.
package cla_pkg;

  localparam int CLA_W    = 64;
  localparam int NREQ_MAX = 8;
  localparam int ID_W_MAX = $clog2(NREQ_MAX);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [CLA_W-1:0]    sum;
    logic                cout;
    logic                last;
`ifdef CLA_ARB_OVF_EN
    logic                ovf;
`endif
  } rsp_t;

  // Wraps to zero after the last requester so non power-of-two counts work.
  function automatic logic [ID_W_MAX-1:0] next_ptr(input logic [ID_W_MAX-1:0] cur,
                                                   input int n);
    logic [ID_W_MAX-1:0] res;
    if (int'(cur) + 1 >= n) res = '0;
    else                    res = cur + 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/cla_64bit.sv
// cla_64bit
// Purely combinational 64-bit carry-lookahead adder built from sixteen 4-bit
// lookahead groups whose group carries are chained.
//   a, b  operands
//   cin   carry in
//   sum   a + b + cin
//   cout  carry out of bit 63
//   pg    whole-word propagate
//   gg    whole-word generate
module cla_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        pg,
  output logic        gg
);

  logic [63:0] g;
  logic [63:0] p;
  logic [15:0] grp_g;
  logic [15:0] grp_p;
  logic [16:0] gc;
  logic [63:0] c;
  logic        gacc;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group generate/propagate from the four bit-level terms.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 16; j++) begin
      grp_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  // Group carries chain across groups; bit carries are resolved inside each
  // group from that group's incoming carry.
  always_comb begin
    gc    = '0;
    c     = '0;
    gacc  = 1'b0;
    gc[0] = cin;
    for (int j = 0; j < 16; j++) begin
      gc[j+1] = grp_g[j] | (grp_p[j] & gc[j]);
      gacc    = grp_g[j] | (grp_p[j] & gacc);
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[16];
  assign pg   = &grp_p;
  assign gg   = gacc;

endmodule

// File: rtl/rr_arb.sv
// rr_arb
// Combinational round-robin pick: first asserted req at or after ptr,
// searching cyclically.
//   req  request vector
//   ptr  highest-priority index
//   gnt  one-hot grant
//   idx  index of the granted requester
//   any  some requester was granted
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Walk N positions from ptr; the first hit wins and masks later ones.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter
// Shares one cla_64bit among NREQ requesters. A round-robin arbiter picks one
// word per cycle; a lock keeps the adder with one requester for a multi-word
// chain so wide add/sub runs word-serially through an internal carry register.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready [NREQ]     per-requester handshake
//   req_a/req_b [NREQ*64]          operands, requester i at [64i+63:64i]
//   req_sub/req_first/req_last     per-requester word controls
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_sum/rsp_cout/rsp_last  registered response word
//   rsp_ovf                        signed overflow (only with CLA_ARB_OVF_EN)
// Optional feature macro: CLA_ARB_OVF_EN.
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*CLA_W-1:0]   req_a,
  input  logic [NREQ*CLA_W-1:0]   req_b,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ-1:0]         req_first,
  input  logic [NREQ-1:0]         req_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [CLA_W-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_last
`ifdef CLA_ARB_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                carry_q, carry_d;
  rsp_t                rsp_q, rsp_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;

  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     sel_idx;
  logic                slot_free;
  logic                accept;

  logic [CLA_W-1:0]    a_sel, b_sel, b_op;
  logic                sel_sub, sel_first, sel_last;
  logic                add_cin;
  logic [CLA_W-1:0]    add_sum;
  logic                add_cout, add_pg, add_gg;
  logic [ID_W_MAX-1:0] ptr_next_full;
  logic                unused_bits;

  rr_arb #(.N(NREQ), .IW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign slot_free = ~rsp_valid_q | rsp_ready;

  // While locked only the owner can win, even if others are waiting.
  always_comb begin
    grant   = '0;
    sel_idx = arb_idx;
    if (state_q == LOCKED) begin
      sel_idx        = owner_q;
      grant[owner_q] = req_valid[owner_q];
    end else begin
      grant = arb_gnt;
    end
  end

  // rst_n gating keeps req_ready low while reset is held.
  assign req_ready = grant & {NREQ{slot_free & rst_n}};
  assign accept    = |req_ready;

  // Operand and control mux for the selected requester.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    sel_sub   = 1'b0;
    sel_first = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(sel_idx)) begin
        a_sel     = req_a[i*CLA_W +: CLA_W];
        b_sel     = req_b[i*CLA_W +: CLA_W];
        sel_sub   = req_sub[i];
        sel_first = req_first[i];
        sel_last  = req_last[i];
      end
    end
  end

  // Subtraction is A + ~B + 1; the +1 enters only on the first word, later
  // words chain from the saved carry.
  assign b_op    = sel_sub ? ~b_sel : b_sel;
  assign add_cin = sel_first ? sel_sub : carry_q;

  cla_64bit u_add (
    .a    (a_sel),
    .b    (b_op),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .pg   (add_pg),
    .gg   (add_gg)
  );

  assign ptr_next_full = next_ptr(ID_W_MAX'(sel_idx), NREQ);

  // Lock, owner and pointer next-state; the pointer only moves when a chain ends.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    carry_d  = carry_q;
    if (accept) begin
      carry_d = add_cout;
      if (state_q == UNLOCKED && !sel_last) begin
        state_d = LOCKED;
        owner_d = sel_idx;
      end
      if (state_q == LOCKED && sel_last) begin
        state_d = UNLOCKED;
      end
      if (sel_last) begin
        rr_ptr_d = ptr_next_full[ID_W-1:0];
      end
    end
  end

  // Response slot: load on accept, otherwise hold until the consumer takes it.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.id    = ID_W_MAX'(sel_idx);
      rsp_d.sum   = add_sum;
      rsp_d.cout  = add_cout;
      rsp_d.last  = sel_last;
`ifdef CLA_ARB_OVF_EN
      // Carry into bit 63 is recovered from the sum bit and its operands.
      rsp_d.ovf   = sel_last & (a_sel[CLA_W-1] ^ b_op[CLA_W-1] ^ add_sum[CLA_W-1] ^ add_cout);
`endif
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // All state registers; reset aborts any chain and drops the pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      carry_q     <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      carry_q     <= carry_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id[ID_W-1:0];
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_last  = rsp_q.last;
`ifdef CLA_ARB_OVF_EN
  assign rsp_ovf   = rsp_q.ovf;
`endif

  // Adder group outputs and wide-pointer/id high bits are intentionally unused.
  assign unused_bits = &{1'b0, add_pg, add_gg, arb_any, ptr_next_full, rsp_q.id};

endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb_cla_add_arbiter
// Directed bench for cla_add_arbiter (NREQ=4): single-word vector table plus
// hand-written chain, lock, round-robin, backpressure and reset sequences.
// Honours CLA_ARB_OVF_EN for the overflow port and its checks.
module tb_cla_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 64;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_first;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_last;
`ifdef CLA_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  int nChecks;
  int nErrors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  vec_t vecs[7];

  cla_add_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_first (req_first),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last)
`ifdef CLA_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_first = '0;
    req_last  = '0;
  endtask

  task automatic setReq(input int i, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub,
                        input logic first, input logic last);
    req_valid[i]       = v;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_sub[i]         = sub;
    req_first[i]       = first;
    req_last[i]        = last;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleAll();
    rsp_ready = 1'b1;
    setReq(0, 1'b1, v.a, v.b, v.sub, 1'b1, 1'b1);
    #1;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[2] = '{64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[5] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    // Reset state, with a requester already asking.
    idleAll();
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    setReq(0, 1'b1, 64'h1, 64'h1, 1'b0, 1'b1, 1'b1);
    #2;
    checkOutput("rst req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst rsp_sum", rsp_sum, 64'h0);
    checkOutput("rst rsp_id", 64'(rsp_id), 64'h0);
    checkOutput("rst rsp_cout", 64'(rsp_cout), 64'h0);
    checkOutput("rst rsp_last", 64'(rsp_last), 64'h0);
    tick();
    tick();
    idleAll();
    rst_n = 1'b1;
    tick();

    // Single-word table on requester 0.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d req_ready", k), 64'(req_ready), 64'h1);
      tick();
      idleAll();
      checkOutput($sformatf("v%0d rsp_valid", k), 64'(rsp_valid), 64'h1);
      checkOutput($sformatf("v%0d rsp_sum", k), rsp_sum, vecs[k].expSum);
      checkOutput($sformatf("v%0d rsp_cout", k), 64'(rsp_cout), 64'(vecs[k].expCout));
      checkOutput($sformatf("v%0d rsp_id", k), 64'(rsp_id), 64'h0);
      checkOutput($sformatf("v%0d rsp_last", k), 64'(rsp_last), 64'h1);
`ifdef CLA_ARB_OVF_EN
      checkOutput($sformatf("v%0d rsp_ovf", k), 64'(rsp_ovf), 64'(vecs[k].expOvf));
`endif
    end

    // 128-bit subtract on requester 2: 0x5_0000..0000 - 1.
    setReq(2, 1'b1, 64'h0, 64'h1, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("sub lo req_ready", 64'(req_ready), 64'h4);
    tick();
    checkOutput("sub lo sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("sub lo cout", 64'(rsp_cout), 64'h0);
    checkOutput("sub lo id", 64'(rsp_id), 64'h2);
    checkOutput("sub lo last", 64'(rsp_last), 64'h0);
`ifdef CLA_ARB_OVF_EN
    checkOutput("sub lo ovf", 64'(rsp_ovf), 64'h0);
`endif
    setReq(2, 1'b1, 64'h5, 64'h0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("sub hi req_ready", 64'(req_ready), 64'h4);
    tick();
    idleAll();
    checkOutput("sub hi sum", rsp_sum, 64'h4);
    checkOutput("sub hi cout", 64'(rsp_cout), 64'h1);
    checkOutput("sub hi last", 64'(rsp_last), 64'h1);

    // Lock: requester 1 holds the adder while 0 and 3 wait.
    setReq(1, 1'b1, 64'h1, 64'h2, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("lock first req_ready", 64'(req_ready), 64'h2);
    tick();
    checkOutput("lock first sum", rsp_sum, 64'h3);
    checkOutput("lock first id", 64'(rsp_id), 64'h1);
    setReq(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    setReq(0, 1'b1, 64'h7, 64'h0, 1'b0, 1'b1, 1'b1);
    setReq(3, 1'b1, 64'h9, 64'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("lock idle%0d req_ready", k), 64'(req_ready), 64'h0);
      tick();
    end
    checkOutput("lock idle rsp_valid", 64'(rsp_valid), 64'h0);
    setReq(1, 1'b1, 64'd10, 64'd20, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("lock last req_ready", 64'(req_ready), 64'h2);
    tick();
    checkOutput("lock last sum", rsp_sum, 64'd30);
    checkOutput("lock last id", 64'(rsp_id), 64'h1);
    setReq(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("post-lock req_ready", 64'(req_ready), 64'h8);
    tick();
    checkOutput("post-lock id", 64'(rsp_id), 64'h3);
    checkOutput("post-lock sum", rsp_sum, 64'h9);
    idleAll();

    // Round-robin with everyone continuously valid; pointer is at 0 here.
    for (int i = 0; i < NREQ; i++) begin
      setReq(i, 1'b1, 64'(i), 64'd100, 1'b0, 1'b1, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("rr%0d id", k), 64'(rsp_id), 64'(k % 4));
      checkOutput($sformatf("rr%0d sum", k), rsp_sum, 64'(k % 4 + 100));
    end

    // Backpressure: response must hold and no requester may be accepted.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid), 64'h1);
      checkOutput($sformatf("bp%0d id", k), 64'(rsp_id), 64'h3);
      checkOutput($sformatf("bp%0d sum", k), rsp_sum, 64'd103);
      checkOutput($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp release req_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("drain0 id", 64'(rsp_id), 64'h0);
    tick();
    checkOutput("drain1 id", 64'(rsp_id), 64'h1);
    idleAll();
    tick();
    checkOutput("drain empty rsp_valid", 64'(rsp_valid), 64'h0);

    // Reset in the middle of requester 0's chain.
    setReq(0, 1'b1, 64'h1, 64'h1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("mid first req_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("mid first last", 64'(rsp_last), 64'h0);
    idleAll();
    setReq(1, 1'b1, 64'h2, 64'h3, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("mid rst rsp_sum", rsp_sum, 64'h0);
    checkOutput("mid rst rsp_id", 64'(rsp_id), 64'h0);
    checkOutput("mid rst req_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("after rst req_ready", 64'(req_ready), 64'h2);
    tick();
    checkOutput("after rst id", 64'(rsp_id), 64'h1);
    checkOutput("after rst sum", rsp_sum, 64'h5);
    checkOutput("after rst last", 64'(rsp_last), 64'h1);
    idleAll();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/cla_add_arbiter.md
# cla_add_arbiter

Shares a single `cla_64bit` adder among `NREQ` requesters, which issue 64-bit add/subtract words through valid/ready handshakes. A round-robin arbiter selects one requester per cycle. A lock mechanism keeps the adder with one requester across a multi-word chain, so wide (N×64-bit) add/sub can be built word-serially with an internal carry. Results return through a single registered response port, tagged with the requester ID.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*64  operand A; requester i drives bits [64i+63:64i].
- `req_b`  in  NREQ*64  operand B, same packing as `req_a`.
- `req_sub`  in  NREQ  1 = A−B (B inverted); 0 = A+B.
- `req_first`  in  NREQ  word is least-significant word of its chain.
- `req_last`  in  NREQ  word is most-significant word of its chain (single word: first=last=1).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(NREQ)  requester index.
- `rsp_sum`  out  64  word result.
- `rsp_cout`  out  1  adder carry-out for this word.
- `rsp_last`  out  1  copy of `req_last` of this word.

## Operation
- **Slot free:** `rsp_valid==0`, or `rsp_valid & rsp_ready` in the same cycle.
- **UNLOCKED:** grant goes to the first valid requester at or after pointer `rr_ptr`, searching cyclically.
- **LOCKED:** grant goes to `owner` only. Other requesters are not granted even if valid.
- **`req_ready[i]`:** `grant[i] & slot_free`. This is combinational from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Accept (valid & ready):**
  - Adder inputs: `a=req_a[i]`, `b=req_sub ? ~req_b[i] : req_b[i]`.
  - `cin = req_first ? req_sub : carry_q`.
  - Register sum, cout, id and last into the response. Update `carry_q <= cout`.
- **State transitions:**
  - UNLOCKED → LOCKED (`owner=i`) on accept with `last=0`.
  - LOCKED → UNLOCKED on owner accept with `last=1`.
- **`rr_ptr` update:** `rr_ptr <= (i+1) mod NREQ` only on an accept with `last=1`. `rr_ptr` is unchanged while locked.
- **Owner drops valid mid-chain:** lock holds indefinitely. No timeout, no bubble insertion from other requesters.
- **`first=1` from the owner mid-chain:** restarts the carry (`cin=req_sub`). The lock continues until `last=1`.
- **`req_sub` differing mid-chain:** each word uses its own `req_sub` for B inversion, with carry from `carry_q`. The result is not meaningful; no error is raised.
- **`first=0` while unlocked:** treated as a continuation and uses the stale `carry_q`. This is a requester error and is not flagged.
- The adder's `pg`/`gg` outputs are unused. Borrow = `~rsp_cout` for subtraction.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `rsp_*` after edge N.
- Throughput is 1 word/cycle when `rsp_ready` stays high.
- `rsp_*` hold stable while `rsp_valid & ~rsp_ready`. `req_ready` is all-zero during the stall.
- The adder path is a single cycle, from request mux through `cla_64bit` to the response register.
- **Reset values:**
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_last=0`.
  - `req_ready=0` during reset.
  - State UNLOCKED, `rr_ptr=0`, `carry_q=0`, `owner=0`.
- Reset mid-chain aborts the chain, clears the lock and drops any pending response.

## Configuration
- **`CLA_ARB_OVF_EN` defined:**
  - Adds output port `rsp_ovf` (1 bit, reset 0).
  - Signed overflow = carry into bit 63 XOR carry out of bit 63. Carry into bit 63 = `a[63]^b'[63]^sum[63]`.
  - Valid only when `rsp_last=1`; forced to 0 on other words.
- **Not defined:** port and logic are absent. All other behaviour is identical.

## Structure
- **Package `cla_pkg`:**
  - `CLA_W=64`.
  - `NREQ_MAX=8`.
  - Arbiter state enum {UNLOCKED, LOCKED}.
  - Response struct {id, sum, cout, last[, ovf]}.
- **Sub-module `rr_arb`:** combinational round-robin grant from `req` and `ptr`, with one-hot output and an index output. Lock override and pointer update stay in the top.
- **Datapath:** exactly one `cla_64bit` instance.

## Test plan
- **Single add:** req0 sends `a=0xFFFF_FFFF_FFFF_FFFF`, `b=1`, add, first=last=1 → next cycle `rsp_sum=0`, `rsp_cout=1`, `rsp_id=0`, `rsp_last=1`.
- **128-bit subtract chain:** req2 sends words (lo `a=0`, `b=1`), then (hi `a=5`, `b=0`), sub → lo `sum=0xFFFF…FFFF`, `cout=0`; hi `sum=4`, `cout=1`.
- **Lock:** req1 starts a chain with `last=0`; req0 and req3 stay valid; req1 idles for 3 cycles before its last word → no grant to others until req1's last word is accepted; next grant goes to req3.
- **Round-robin fairness:** all 4 requesters continuously valid with single words → `rsp_id` sequence 0,1,2,3,0,1,…
- **Backpressure:** hold `rsp_ready=0` for 5 cycles with `rsp_valid=1` → `rsp_*` stable, `req_ready=0`; release → drains at 1 word/cycle.
- **Reset mid-chain / overflow:**
  - Assert `rst_n=0` after req0's first word → all outputs at reset values; after release, req1 is granted first.
  - With `CLA_ARB_OVF_EN`: `0x7FFF…FFFF + 1` → `rsp_ovf=1`.
